// File: rtl/craft_pkg.sv
// craft_pkg: constants shared by the CRAFT-64/128 cores.
//   - CRAFT_ROUNDS           : round count (32)
//   - PN_TAB / pn_inv_idx()  : nibble permutation PN and its inverse
//   - Q_TAB / q_perm()       : tweak nibble permutation Q
//   - RC_TAB                 : 8-bit round constants, {RC3, RC4} per round
//   - dec_state_e            : decryptor FSM encoding
//   - dec_req_t              : bundled decrypt request (ciphertext, tweak, key)
// Nibble 0 of every 64-bit word is bits [63:60].
package craft_pkg;

    localparam int CRAFT_ROUNDS = 32;

    localparam int PN_TAB [16] = '{15, 12, 13, 14, 10, 9, 8, 11, 6, 5, 4, 7, 1, 2, 3, 0};
    localparam int Q_TAB  [16] = '{12, 10, 15, 5, 14, 8, 9, 2, 11, 3, 7, 4, 6, 0, 1, 13};

    localparam logic [7:0] RC_TAB [32] = '{
        8'h11, 8'h84, 8'h42, 8'h25, 8'h96, 8'hc7, 8'h63, 8'hb1,
        8'h54, 8'ha2, 8'hd5, 8'he6, 8'hf7, 8'h73, 8'h31, 8'h14,
        8'h82, 8'h45, 8'h26, 8'h97, 8'hc3, 8'h61, 8'hb4, 8'h52,
        8'ha5, 8'hd6, 8'he7, 8'hf3, 8'h71, 8'h34, 8'h12, 8'h85
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } dec_state_e;

    typedef struct packed {
        logic [63:0]  ct;
        logic [63:0]  tweak;
        logic [127:0] key;
    } dec_req_t;

    // Encryption moves nibble PN[j] to position j, so decryption takes
    // position j from the k with PN[k] == j.
    function automatic int pn_inv_idx(input int j);
        int r;
        r = 0;
        for (int k = 0; k < 16; k++) begin
            if (PN_TAB[k] == j) r = k;
        end
        return r;
    endfunction

    function automatic logic [63:0] q_perm(input logic [63:0] t);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < 16; j++) begin
            r[63-4*j -: 4] = t[63-4*Q_TAB[j] -: 4];
        end
        return r;
    endfunction

endpackage

// File: rtl/craft_inv_round.sv
// craft_inv_round: one combinational CRAFT inverse round.
//   state_i   : round input state
//   tk_i      : round tweakey TK[i mod 4]
//   rc_i      : round constant RC[i] (high nibble -> nibble 4, low -> nibble 5)
//   skip_pn_i : bypass PN^-1 (the first inverse round, i == 31)
//   state_o   : round output state
// Order: SB, PN^-1, add tweakey, add constant, MC.
module craft_inv_round
    import craft_pkg::*;
(
    input  logic [63:0] state_i,
    input  logic [63:0] tk_i,
    input  logic [7:0]  rc_i,
    input  logic        skip_pn_i,
    output logic [63:0] state_o
);

    logic [63:0] sb;
    logic [63:0] pn;
    logic [63:0] mix;
    logic [63:0] ak;

    for (genvar j = 0; j < 16; j++) begin : g_nib
        localparam int SRC = pn_inv_idx(j);
        craft_sbox u_sbox (
            .x_i (state_i[63-4*j -: 4]),
            .y_o (sb[63-4*j -: 4])
        );
        assign pn[63-4*j -: 4] = sb[63-4*SRC -: 4];
    end

    assign mix = skip_pn_i ? sb : pn;
    assign ak  = mix ^ tk_i ^ {16'h0, rc_i, 40'h0};

    // MC on 16-bit rows: row0 ^= row2 ^ row3, row1 ^= row3; rows 2,3 pass.
    assign state_o = {ak[63:48] ^ ak[31:16] ^ ak[15:0],
                      ak[47:32] ^ ak[15:0],
                      ak[31:0]};

endmodule

// File: rtl/craft_sbox.sv
// craft_sbox: CRAFT 4-bit S-box (an involution, so it serves both directions).
//   x_i : input nibble
//   y_o : substituted nibble
module craft_sbox (
    input  logic [3:0] x_i,
    output logic [3:0] y_o
);

    always_comb begin
        y_o = 4'h0;
        case (x_i)
            4'h0: y_o = 4'hc;
            4'h1: y_o = 4'ha;
            4'h2: y_o = 4'hd;
            4'h3: y_o = 4'h3;
            4'h4: y_o = 4'he;
            4'h5: y_o = 4'hb;
            4'h6: y_o = 4'hf;
            4'h7: y_o = 4'h7;
            4'h8: y_o = 4'h8;
            4'h9: y_o = 4'h9;
            4'ha: y_o = 4'h1;
            4'hb: y_o = 4'h5;
            4'hc: y_o = 4'h0;
            4'hd: y_o = 4'h2;
            4'he: y_o = 4'h4;
            default: y_o = 4'h6;
        endcase
    end

endmodule

// File: rtl/craft_decrypt.sv
// craft_decrypt: iterative CRAFT-64/128 tweakable block decryptor,
// one inverse round per clock (32 rounds).
//   clk_i        : clock, rising edge
//   rst_i        : asynchronous active-high reset
//   start_i      : request, sampled in IDLE only
//   ciphertext_i : 64b block input
//   tweak_i      : 64b tweak
//   key_i        : 128b key, K0 = [127:64], K1 = [63:0]
//   abort_i      : (CRAFT_DEC_ABORT_EN only) drop the running decryption
//   busy_o       : high while rounds are running
//   done_o       : one-cycle pulse, plaintext_o valid
//   plaintext_o  : result, held until the next completed decryption
// Optional feature macro: CRAFT_DEC_ABORT_EN.
module craft_decrypt
    import craft_pkg::*;
#(
    parameter int ROUNDS = CRAFT_ROUNDS,
    parameter int RCNT_W = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [63:0]  ciphertext_i,
    input  logic [63:0]  tweak_i,
    input  logic [127:0] key_i,
`ifdef CRAFT_DEC_ABORT_EN
    input  logic         abort_i,
`endif
    output logic         busy_o,
    output logic         done_o,
    output logic [63:0]  plaintext_o
);

    dec_state_e         fsm_q, fsm_d;
    logic [63:0]        st_q, st_d;
    logic [3:0][63:0]   tk_q, tk_d;
    logic [RCNT_W-1:0]  rcnt_q, rcnt_d;
    logic [63:0]        pt_q, pt_d;

    dec_req_t           req;
    logic [63:0]        qt;
    logic [63:0]        rnd_out;
    logic               abort_w;

    assign req = '{ct: ciphertext_i, tweak: tweak_i, key: key_i};
    assign qt  = q_perm(req.tweak);

`ifdef CRAFT_DEC_ABORT_EN
    assign abort_w = abort_i;
`else
    assign abort_w = 1'b0;
`endif

    craft_inv_round u_round (
        .state_i   (st_q),
        .tk_i      (tk_q[rcnt_q[1:0]]),
        .rc_i      (RC_TAB[rcnt_q]),
        .skip_pn_i (rcnt_q == RCNT_W'(ROUNDS - 1)),
        .state_o   (rnd_out)
    );

    always_comb begin
        fsm_d  = fsm_q;
        st_d   = st_q;
        tk_d   = tk_q;
        rcnt_d = rcnt_q;
        pt_d   = pt_q;
        case (fsm_q)
            ST_IDLE: begin
                if (start_i) begin
                    st_d    = req.ct;
                    tk_d[0] = req.key[127:64] ^ req.tweak;
                    tk_d[1] = req.key[63:0]   ^ req.tweak;
                    tk_d[2] = req.key[127:64] ^ qt;
                    tk_d[3] = req.key[63:0]   ^ qt;
                    rcnt_d  = RCNT_W'(ROUNDS - 1);
                    fsm_d   = ST_ROUND;
                end
            end
            ST_ROUND: begin
                // abort wins over the final round, so plaintext is untouched
                if (abort_w) begin
                    fsm_d = ST_IDLE;
                end else begin
                    st_d = rnd_out;
                    if (rcnt_q == '0) begin
                        pt_d  = rnd_out;
                        fsm_d = ST_DONE;
                    end else begin
                        rcnt_d = rcnt_q - 1'b1;
                    end
                end
            end
            ST_DONE: fsm_d = ST_IDLE;
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm_q  <= ST_IDLE;
            st_q   <= '0;
            tk_q   <= '0;
            rcnt_q <= '0;
            pt_q   <= '0;
        end else begin
            fsm_q  <= fsm_d;
            st_q   <= st_d;
            tk_q   <= tk_d;
            rcnt_q <= rcnt_d;
            pt_q   <= pt_d;
        end
    end

    assign busy_o      = (fsm_q == ST_ROUND);
    assign done_o      = (fsm_q == ST_DONE);
    assign plaintext_o = pt_q;

endmodule

// File: tb/tb_craft_decrypt.sv
// Testbench for craft_decrypt. Ciphertexts come from an independent CRAFT
// encryption model (round constants generated by the LFSRs); expected
// plaintexts are queued at start and checked when done pulses.
module tb_craft_decrypt;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         start_i;
    logic [63:0]  ciphertext_i;
    logic [63:0]  tweak_i;
    logic [127:0] key_i;
    logic         abort_i;
    logic         busy_o;
    logic         done_o;
    logic [63:0]  plaintext_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    craft_decrypt dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .ciphertext_i (ciphertext_i),
        .tweak_i      (tweak_i),
        .key_i        (key_i),
`ifdef CRAFT_DEC_ABORT_EN
        .abort_i      (abort_i),
`endif
        .busy_o       (busy_o),
        .done_o       (done_o),
        .plaintext_o  (plaintext_o)
    );

    localparam int SB [16] = '{12, 10, 13, 3, 14, 11, 15, 7, 8, 9, 1, 5, 0, 2, 4, 6};
    localparam int PB [16] = '{15, 12, 13, 14, 10, 9, 8, 11, 6, 5, 4, 7, 1, 2, 3, 0};
    localparam int QB [16] = '{12, 10, 15, 5, 14, 8, 9, 2, 11, 3, 7, 4, 6, 0, 1, 13};

    // Forward CRAFT: MC, RC, tweakey, PN (not in last round), SB.
    function automatic logic [63:0] enc(input logic [63:0] p, input logic [63:0] t,
                                        input logic [127:0] k);
        logic [3:0] x [16];
        logic [3:0] y [16];
        logic [3:0] tk [4][16];
        logic [3:0] a;
        logic [2:0] b;
        logic [63:0] r;
        a = 4'h1;
        b = 3'h1;
        for (int j = 0; j < 16; j++) begin
            x[j]     = p[63-4*j -: 4];
            tk[0][j] = k[127-4*j -: 4] ^ t[63-4*j -: 4];
            tk[1][j] = k[63-4*j -: 4]  ^ t[63-4*j -: 4];
            tk[2][j] = k[127-4*j -: 4] ^ t[63-4*QB[j] -: 4];
            tk[3][j] = k[63-4*j -: 4]  ^ t[63-4*QB[j] -: 4];
        end
        for (int rd = 0; rd < 32; rd++) begin
            for (int j = 0; j < 4; j++) begin
                x[j]   = x[j] ^ x[j+8] ^ x[j+12];
                x[j+4] = x[j+4] ^ x[j+12];
            end
            x[4] = x[4] ^ a;
            x[5] = x[5] ^ {1'b0, b};
            a = {a[0] ^ a[1], a[3:1]};
            b = {b[0] ^ b[1], b[2:1]};
            for (int j = 0; j < 16; j++) x[j] = x[j] ^ tk[rd % 4][j];
            if (rd != 31) begin
                for (int j = 0; j < 16; j++) y[j] = x[PB[j]];
                for (int j = 0; j < 16; j++) x[j] = y[j];
            end
            for (int j = 0; j < 16; j++) x[j] = 4'(SB[x[j]]);
        end
        r = '0;
        for (int j = 0; j < 16; j++) r[63-4*j -: 4] = x[j];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every done must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst_i && done_o) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", 128'(done_o), 128'(0));
            end else begin
                chk("plaintext", 128'(plaintext_o), 128'(exp_q.pop_front()));
            end
        end
    end

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    task automatic scramble();
        ciphertext_i = r64();
        tweak_i      = r64();
        key_i        = {r64(), r64()};
    endtask

    task automatic start_op(input logic [63:0] ct, input logic [63:0] tw,
                            input logic [127:0] k, input logic [63:0] exp, input bit push);
        @(posedge clk);
        #1;
        ciphertext_i = ct;
        tweak_i      = tw;
        key_i        = k;
        start_i      = 1'b1;
        if (push) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        scramble();
    endtask

    // lat counts edges after the accepting edge until done is seen.
    task automatic wait_done(input int pa, input int pb, output int lat, output int bb);
        @(negedge clk);
        lat = 0;
        bb  = 0;
        while (!done_o && lat < 40) begin
            if (!busy_o) bb++;
            start_i = (lat == pa || lat == pb);
            scramble();
            @(negedge clk);
            lat++;
        end
        start_i = 1'b0;
    endtask

    task automatic run_chk(input string nm, input logic [63:0] ct, input logic [63:0] tw,
                           input logic [127:0] k, input logic [63:0] exp,
                           input int pa, input int pb);
        int lat, bb;
        start_op(ct, tw, k, exp, 1'b1);
        wait_done(pa, pb, lat, bb);
        chk({nm, "_latency"}, 128'(lat), 128'(32));
        chk({nm, "_busy"}, 128'(bb), 128'(0));
        @(negedge clk);
        chk({nm, "_hold"}, 128'(plaintext_o), 128'(exp));
        chk({nm, "_done_pulse"}, 128'(done_o), 128'(0));
    endtask

    typedef struct {
        string        nm;
        logic [63:0]  ct;
        logic [63:0]  tw;
        logic [127:0] key;
        logic [63:0]  pt;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [63:0]  p, t, prev;
        logic [127:0] k;

        vecs[0] = '{"zero",   '0, 64'h0, 128'h0, 64'h0};
        vecs[1] = '{"count",  '0, 64'h0123456789abcdef, 128'hfedcba9876543210_0011223344556677,
                    64'h0011223344556677};
        vecs[2] = '{"ones",   '0, 64'hffffffffffffffff, 128'hffffffffffffffff_ffffffffffffffff,
                    64'hffffffffffffffff};
        vecs[3] = '{"keyonly", '0, 64'h0, 128'h27a6781a43f364bc_916708d5fbb5aeaa,
                    64'h5734f006d8d88a3e};
        vecs[4] = '{"tweak",  '0, 64'h5434f2d68fdc7c0a, 128'h0, 64'h8000000000000001};
        foreach (vecs[i]) vecs[i].ct = enc(vecs[i].pt, vecs[i].tw, vecs[i].key);

        rst_i        = 1'b1;
        start_i      = 1'b0;
        abort_i      = 1'b0;
        ciphertext_i = '0;
        tweak_i      = '0;
        key_i        = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 128'(busy_o), 128'(0));
        chk("reset_done", 128'(done_o), 128'(0));
        chk("reset_pt", 128'(plaintext_o), 128'(0));
        rst_i = 1'b0;

        foreach (vecs[i]) run_chk(vecs[i].nm, vecs[i].ct, vecs[i].tw, vecs[i].key, vecs[i].pt, -1, -1);

        for (int n = 0; n < 1000; n++) begin
            p = r64();
            t = r64();
            k = {r64(), r64()};
            run_chk("random", enc(p, t, k), t, k, p, -1, -1);
        end

        // start pulses at cycles 5 and 10 of a running decryption are ignored
        run_chk("start_busy", vecs[1].ct, vecs[1].tw, vecs[1].key, vecs[1].pt, 5, 10);

        // reset mid-run clears everything, then a fresh run completes
        start_op(vecs[2].ct, vecs[2].tw, vecs[2].key, vecs[2].pt, 1'b1);
        repeat (17) @(negedge clk);
        rst_i = 1'b1;
        #1;
        chk("midrst_busy", 128'(busy_o), 128'(0));
        chk("midrst_done", 128'(done_o), 128'(0));
        chk("midrst_pt", 128'(plaintext_o), 128'(0));
        exp_q.delete();
        @(negedge clk);
        rst_i = 1'b0;
        run_chk("after_rst", vecs[4].ct, vecs[4].tw, vecs[4].key, vecs[4].pt, -1, -1);

`ifdef CRAFT_DEC_ABORT_EN
        prev = vecs[4].pt;
        start_op(vecs[1].ct, vecs[1].tw, vecs[1].key, vecs[1].pt, 1'b0);
        repeat (20) @(negedge clk);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        chk("abort_busy", 128'(busy_o), 128'(0));
        chk("abort_pt", 128'(plaintext_o), 128'(prev));
        repeat (40) @(negedge clk);
        chk("abort_pt_later", 128'(plaintext_o), 128'(prev));
        run_chk("after_abort", vecs[3].ct, vecs[3].tw, vecs[3].key, vecs[3].pt, -1, -1);
`else
        prev = '0;
`endif

        repeat (40) @(negedge clk);
        chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
